// File: rtl/control_sequencer.sv
// control_sequencer: fetch/load/exec instruction sequencer driving the ALU/accumulator block
// Ports: clk, rst_n (async active-low); run gates leaving FETCH; prog_data is the
// synchronous program memory word for prog_addr (=PC); Carry_flag is the ALU carry.
// Outputs operation_code/in_b come straight from IR, aku_enable pulses once per ALU
// instruction, carry_q is the carry latched for JC, halted sticks until reset.
module control_sequencer #(
  parameter int ADDR_W = 8,
  parameter int IW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [IW-1:0]     prog_data,
  input  logic              Carry_flag,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [2:0]        operation_code,
  output logic              aku_enable,
  output logic [7:0]        in_b,
  output logic              carry_q,
  output logic              halted
);
  typedef enum logic [1:0] {FETCH, LOAD, EXEC, HALT} state_t;
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [IW-1:0]     ir;
  logic              is_alu, is_jmp, is_jc, is_halt;
  logic [ADDR_W-1:0] next_pc;
  assign is_alu  = ~ir[11];
  assign is_jmp  = ir[11:8] == 4'h8;
  assign is_jc   = ir[11:8] == 4'h9;
  assign is_halt = ir[11:8] == 4'hB;
  // JC tests the carry latched by an earlier ALU instruction, never this cycle's Carry_flag
  assign next_pc = (is_jmp | (is_jc & carry_q)) ? ir[ADDR_W-1:0] :
                   is_halt ? pc : pc + ADDR_W'(1);
  assign prog_addr      = pc;
  assign operation_code = ir[10:8];
  assign in_b           = ir[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= IW'(12'hA00);
      carry_q    <= 1'b0;
      halted     <= 1'b0;
      aku_enable <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= run ? LOAD : FETCH;
        LOAD: begin
          ir         <= prog_data;
          aku_enable <= ~prog_data[11];
          state      <= EXEC;
        end
        EXEC: begin
          aku_enable <= 1'b0;
          if (is_alu) carry_q <= Carry_flag;
          pc     <= next_pc;
          halted <= is_halt;
          state  <= is_halt ? HALT : FETCH;
        end
        HALT: begin
          aku_enable <= 1'b0;
          halted     <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven and directed checks of control_sequencer
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [11:0] prog_data = 12'hA00;
  logic        carry_flag = 1'b0;
  logic [7:0]  prog_addr;
  logic [2:0]  operation_code;
  logic        aku_enable;
  logic [7:0]  in_b;
  logic        carry_q;
  logic        halted;
  logic [11:0] mem [256];
  int checks = 0;
  int errors = 0;
  int aku_seen = 0;

  control_sequencer #(.ADDR_W(8), .IW(12)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_data(prog_data),
    .Carry_flag(carry_flag), .prog_addr(prog_addr), .operation_code(operation_code),
    .aku_enable(aku_enable), .in_b(in_b), .carry_q(carry_q), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) prog_data <= mem[prog_addr];

  typedef struct {
    logic       run;
    logic       cf;
    logic [7:0] pa;
    logic [2:0] op;
    logic [7:0] ib;
    logic       aku;
    logic       cq;
    logic       h;
  } vec_t;
  vec_t tv [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (aku_enable) aku_seen++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'hA00;
  endtask

  task automatic do_reset(input logic r);
    rst_n = 1'b0;
    run = 1'b0;
    carry_flag = 1'b0;
    tick();
    tick();
    run = r;
    rst_n = 1'b1;
    aku_seen = 0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 8'h00, 3'd3, 8'h0A, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 8'h01, 3'd0, 8'h0A, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 8'h01, 3'd0, 8'h0A, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 8'h01, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 8'h02, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 8'h02, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 8'h02, 3'd1, 8'h55, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 8'h03, 3'd0, 8'h55, 1'b0, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 8'h03, 3'd0, 8'h55, 1'b0, 1'b1, 1'b0};
    tv[11] = '{1'b1, 1'b0, 8'h03, 3'd0, 8'h20, 1'b0, 1'b1, 1'b0};
    tv[12] = '{1'b1, 1'b0, 8'h20, 3'd0, 8'h20, 1'b0, 1'b1, 1'b0};
    tv[13] = '{1'b1, 1'b0, 8'h20, 3'd0, 8'h20, 1'b0, 1'b1, 1'b0};
    tv[14] = '{1'b1, 1'b0, 8'h20, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tv[15] = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tv[16] = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tv[17] = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0};
    tv[18] = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0};

    // ALU, NOP, ALU with carry, JC taken, JMP to 0xFF, ALU at 0xFF, wrap to 0
    clear_mem();
    mem[8'h00] = 12'h30A;
    mem[8'h01] = 12'hA00;
    mem[8'h02] = 12'h155;
    mem[8'h03] = 12'h920;
    mem[8'h20] = 12'h8FF;
    mem[8'hFF] = 12'h001;
    do_reset(1'b1);
    chk("reset_halted", halted, 0);
    for (int i = 0; i < 19; i++) begin
      run = tv[i].run;
      carry_flag = tv[i].cf;
      chk($sformatf("v%0d_prog_addr", i), prog_addr, tv[i].pa);
      chk($sformatf("v%0d_in_b", i), in_b, tv[i].ib);
      chk($sformatf("v%0d_aku_enable", i), aku_enable, tv[i].aku);
      chk($sformatf("v%0d_carry_q", i), carry_q, tv[i].cq);
      chk($sformatf("v%0d_halted", i), halted, tv[i].h);
      if (tv[i].aku) chk($sformatf("v%0d_opcode", i), operation_code, tv[i].op);
      tick();
    end

    // JC not taken when the preceding ALU op left carry clear
    clear_mem();
    mem[8'h00] = 12'h155;
    mem[8'h01] = 12'h920;
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("jc_not_taken_addr", prog_addr, 8'h02);
    chk("jc_not_taken_carry", carry_q, 0);

    // stall: run low keeps FETCH at address 0, then a normal 3-cycle instruction
    clear_mem();
    mem[8'h00] = 12'h30A;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_addr", prog_addr, 8'h00);
    chk("stall_no_aku", aku_seen, 0);
    run = 1'b1;
    tick();
    chk("stall_load_aku", aku_enable, 0);
    tick();
    chk("stall_exec_aku", aku_enable, 1);
    chk("stall_exec_op", operation_code, 3);
    run = 1'b0;
    tick();
    chk("stall_next_addr", prog_addr, 8'h01);
    chk("stall_pulse_count", aku_seen, 1);

    // HALT freezes the sequencer regardless of run until reset
    clear_mem();
    mem[8'h00] = 12'hB00;
    mem[8'h01] = 12'h1FF;
    do_reset(1'b1);
    tick();
    tick();
    chk("halt_exec_halted", halted, 0);
    tick();
    chk("halt_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick();
    end
    chk("halt_hold_halted", halted, 1);
    chk("halt_hold_addr", prog_addr, 8'h00);
    chk("halt_no_aku", aku_seen, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_reset_halted", halted, 0);
    tick();
    rst_n = 1'b1;
    run = 1'b1;
    chk("halt_restart_addr", prog_addr, 8'h00);
    tick();
    tick();
    tick();
    chk("halt_again", halted, 1);

    // asynchronous reset in the middle of an ALU EXEC cycle
    clear_mem();
    mem[8'h00] = 12'h155;
    mem[8'h01] = 12'h30A;
    do_reset(1'b1);
    carry_flag = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("arst_pre_aku", aku_enable, 1);
    chk("arst_pre_carry", carry_q, 1);
    chk("arst_pre_addr", prog_addr, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_aku", aku_enable, 0);
    chk("arst_carry", carry_q, 0);
    chk("arst_addr", prog_addr, 8'h00);
    chk("arst_in_b", in_b, 8'h00);
    chk("arst_halted", halted, 0);
    tick();
    chk("arst_held_aku", aku_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
